// File: rtl/dfb_spi_master.sv
// dfb_spi_master
//   SPI master for the DFB register window. Words are queued in a small TX
//   FIFO and shifted out with a configurable word width, divider, SPI mode,
//   bit order and chip select. Each received word is placed in a single
//   holding register. A sticky flag records any word that overwrote an
//   unread one. Everything runs on posedge CLKOSC. RST is an asynchronous,
//   active-high reset.
// Ports
//   CLKOSC, RST            clock and asynchronous active-high reset
//   tx_data/valid/ready    TX FIFO push interface (push = tx_valid & tx_ready)
//   rx_data/valid, rx_ack  last received word, unread flag, consume strobe
//   clr_ovr, overrun       clear strobe and sticky overrun flag
//   div                    half SCK period = div+1 CLKOSC cycles
//   cpol, cpha, lsb_first  SPI mode and bit order (TX and RX)
//   cs_sel                 chip-select index for the next transfer
//   busy                   FSM active or FIFO non-empty
//   spi_clk, spi_mosi, spi_miso, spi_cs_n   SPI pins
module dfb_spi_master #(
    parameter int DATA_W     = 8,
    parameter int NUM_CS     = 2,
    parameter int DIV_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                         CLKOSC,
    input  logic                                         RST,
    input  logic [DATA_W-1:0]                            tx_data,
    input  logic                                         tx_valid,
    output logic                                         tx_ready,
    output logic [DATA_W-1:0]                            rx_data,
    output logic                                         rx_valid,
    input  logic                                         rx_ack,
    input  logic                                         clr_ovr,
    output logic                                         overrun,
    input  logic [DIV_W-1:0]                             div,
    input  logic                                         cpol,
    input  logic                                         cpha,
    input  logic                                         lsb_first,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    output logic                                         busy,
    output logic                                         spi_clk,
    output logic                                         spi_mosi,
    input  logic                                         spi_miso,
    output logic [NUM_CS-1:0]                            spi_cs_n
);

    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    // Bit-order helpers. Both directions use the same order, so a loopback
    // returns the transmitted word unchanged.
    function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] d;
        for (int i = 0; i < NUM_CS; i++) begin
            d[i] = !(sel == CS_W'(i));
        end
        return d;
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg;
    logic              fifo_empty, fifo_full, push, pop;
    logic [DATA_W-1:0] fifo_head;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign push       = tx_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge CLKOSC) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge CLKOSC or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
        end
    end

    // ---------------- Shift engine ----------------
    state_t            state_reg;
    logic [DIV_W-1:0]  cnt_reg, div_l_reg;
    logic [EDGE_W-1:0] edge_reg, edge_next;
    logic              cpol_l_reg, cpha_l_reg, lsb_l_reg;
    logic [DATA_W-1:0] tx_shift_reg, rx_shift_reg, load_shift;
    logic              spi_clk_reg, spi_mosi_reg;
    logic [NUM_CS-1:0] cs_n_reg;
    logic              phase_end, last_edge, do_edge, sample_edge, drive_edge, deliver;
    logic              lsb_eff, cpha_eff;

    always_comb begin
        // A pop from IDLE uses the live config (latched in the same cycle);
        // a back-to-back pop from HOLD keeps the latched one.
        lsb_eff     = (state_reg == IDLE) ? lsb_first : lsb_l_reg;
        cpha_eff    = (state_reg == IDLE) ? cpha : cpha_l_reg;
        load_shift  = cpha_eff ? fifo_head : shift_tx(fifo_head, lsb_eff);
        phase_end   = (cnt_reg == div_l_reg);
        edge_next   = edge_reg + EDGE_W'(1);
        last_edge   = (edge_reg == EDGE_W'(2 * DATA_W));
        // SCK edge k happens at the start of SHIFT half period k (k=1..2*DATA_W).
        do_edge     = phase_end && ((state_reg == SETUP) || ((state_reg == SHIFT) && !last_edge));
        // Odd edges are leading. CPHA=0 samples on leading, CPHA=1 on trailing.
        sample_edge = edge_next[0] ^ cpha_l_reg;
        drive_edge  = !sample_edge && (edge_next != EDGE_W'(2 * DATA_W));
        deliver     = (state_reg == SHIFT) && phase_end && last_edge;
        pop         = !fifo_empty &&
                      ((state_reg == IDLE) || ((state_reg == HOLD) && phase_end));
    end

    always_ff @(posedge CLKOSC or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            div_l_reg    <= '0;
            edge_reg     <= '0;
            cpol_l_reg   <= 1'b0;
            cpha_l_reg   <= 1'b0;
            lsb_l_reg    <= 1'b0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            spi_clk_reg  <= 1'b0;
            spi_mosi_reg <= 1'b1;
            cs_n_reg     <= '1;
        end else begin
            cnt_reg <= (state_reg == IDLE || phase_end) ? '0 : cnt_reg + DIV_W'(1);

            if (pop) begin
                tx_shift_reg <= load_shift;
                rx_shift_reg <= '0;
                edge_reg     <= '0;
                state_reg    <= SETUP;
                if (!cpha_eff) spi_mosi_reg <= out_bit(fifo_head, lsb_eff);
            end

            if (do_edge) begin
                spi_clk_reg <= ~spi_clk_reg;
                edge_reg    <= edge_next;
                if (sample_edge) rx_shift_reg <= shift_rx(rx_shift_reg, spi_miso, lsb_l_reg);
                if (drive_edge) begin
                    spi_mosi_reg <= out_bit(tx_shift_reg, lsb_l_reg);
                    tx_shift_reg <= shift_tx(tx_shift_reg, lsb_l_reg);
                end
            end

            case (state_reg)
                IDLE: begin
                    spi_clk_reg <= cpol;
                    if (pop) begin
                        div_l_reg  <= div;
                        cpol_l_reg <= cpol;
                        cpha_l_reg <= cpha;
                        lsb_l_reg  <= lsb_first;
                        cs_n_reg   <= cs_decode(cs_sel);
                    end
                end
                SETUP: if (phase_end) state_reg <= SHIFT;
                SHIFT: if (deliver) state_reg <= HOLD;
                HOLD: begin
                    if (phase_end && !pop) begin
                        state_reg    <= GAP;
                        cs_n_reg     <= '1;
                        spi_mosi_reg <= 1'b1;
                    end
                end
                GAP: begin
                    spi_clk_reg <= cpol_l_reg;
                    if (phase_end) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ---------------- RX holding register ----------------
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg, overrun_reg;

    always_ff @(posedge CLKOSC or posedge RST) begin
        if (RST) begin
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (clr_ovr) overrun_reg <= 1'b0;
            if (deliver) begin
                rx_data_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
                // Placed after the clear so a simultaneous overrun wins.
                if (rx_valid_reg && !rx_ack) overrun_reg <= 1'b1;
            end else if (rx_ack) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign tx_ready = !fifo_full;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign overrun  = overrun_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty;
    assign spi_clk  = spi_clk_reg;
    assign spi_mosi = spi_mosi_reg;
    assign spi_cs_n = cs_n_reg;

endmodule

// File: tb/tb_dfb_spi_master.sv
// Directed testbench for dfb_spi_master (DATA_W=8, NUM_CS=2, DIV_W=8, FIFO_DEPTH=4).
module tb_dfb_spi_master;

    logic        CLKOSC = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        clr_ovr;
    logic        overrun;
    logic [7:0]  div;
    logic        cpol, cpha, lsb_first;
    logic [0:0]  cs_sel;
    logic        busy;
    logic        spi_clk, spi_mosi, spi_miso;
    logic [1:0]  spi_cs_n;
    logic        loop_en, miso_val;

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    dfb_spi_master #(.DATA_W(8), .NUM_CS(2), .DIV_W(8), .FIFO_DEPTH(4)) dut (
        .CLKOSC(CLKOSC), .RST(RST),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .clr_ovr(clr_ovr), .overrun(overrun),
        .div(div), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cs_sel(cs_sel),
        .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );

    always #5 CLKOSC = ~CLKOSC;

    // Pin monitors
    int          sck_rises = 0;
    logic [31:0] mosi_hist = '0;
    int          cs0_low = 0, cs1_low = 0, cs_rel = 0;
    logic        cs_prev_low = 1'b0;

    always @(posedge spi_clk) begin
        sck_rises <= sck_rises + 1;
        mosi_hist <= {mosi_hist[30:0], spi_mosi};
    end

    always @(negedge CLKOSC) begin
        if (!spi_cs_n[0]) cs0_low <= cs0_low + 1;
        if (!spi_cs_n[1]) cs1_low <= cs1_low + 1;
        cs_prev_low <= ~&spi_cs_n;
        if (cs_prev_low && (&spi_cs_n)) cs_rel <= cs_rel + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge CLKOSC);
        while (!tx_ready && n < 1000) begin
            @(negedge CLKOSC);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge CLKOSC);
        #1 tx_valid = 1'b0;
        $display("push %02h", d);
    endtask

    task automatic wait_rx(input int limit);
        int n;
        n = 0;
        while (!rx_valid && n < limit) begin
            @(negedge CLKOSC);
            n++;
        end
        chk("rx_timeout", {31'd0, rx_valid}, 32'd1);
        $display("rx %02h overrun=%0b", rx_data, overrun);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        @(negedge CLKOSC);
        rx_ack = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge CLKOSC);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_rises(input int base, input int cnt, input int limit);
        int n;
        n = 0;
        while ((sck_rises - base) < cnt && n < limit) begin
            @(negedge CLKOSC);
            n++;
        end
        chk("shift_reached", {31'd0, (sck_rises - base) >= cnt}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rise, b_cs0, b_cs1, b_rel, n, hp;
        logic [7:0] w3 [5];
        w3 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};

        tx_data = '0; tx_valid = 0; rx_ack = 0; clr_ovr = 0;
        div = 8'd0; cpol = 0; cpha = 0; lsb_first = 0; cs_sel = 1'b0;
        loop_en = 1; miso_val = 0;

        // Reset state
        repeat (3) @(negedge CLKOSC);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_spi_clk", {31'd0, spi_clk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("rst_cs_n", {30'd0, spi_cs_n}, 32'd3);
        RST = 1'b0;
        @(negedge CLKOSC);

        // 1: mode 0, div 0, loopback 0xA5
        b_rise = sck_rises; b_cs0 = cs0_low;
        push(8'hA5);
        wait_rx(100);
        chk("t1_rx_data", {24'd0, rx_data}, 32'hA5);
        ack();
        wait_idle(100);
        chk("t1_cs_low_cycles", cs0_low - b_cs0, 32'd18);
        chk("t1_sck_rises", sck_rises - b_rise, 32'd8);
        chk("t1_mosi_bits", {24'd0, mosi_hist[7:0]}, 32'hA5);
        chk("t1_rx_valid_acked", {31'd0, rx_valid}, 32'd0);

        // 2: mode 3, div 3, LSB first, MISO tied high, 0x01
        cpol = 1; cpha = 1; div = 8'd3; lsb_first = 1; loop_en = 0; miso_val = 1;
        repeat (3) @(negedge CLKOSC);
        chk("t2_sck_idle", {31'd0, spi_clk}, 32'd1);
        b_rise = sck_rises;
        push(8'h01);
        n = 0;
        while (spi_clk && n < 100) begin
            @(negedge CLKOSC);
            n++;
        end
        hp = 0;
        while (!spi_clk && hp < 100) begin
            hp++;
            @(negedge CLKOSC);
        end
        chk("t2_half_period", hp, 32'd4);
        wait_rx(300);
        chk("t2_rx_data", {24'd0, rx_data}, 32'hFF);
        ack();
        wait_idle(100);
        chk("t2_mosi_bits", {24'd0, mosi_hist[7:0]}, 32'h80);
        chk("t2_sck_rises", sck_rises - b_rise, 32'd8);

        // 3: mode 1, div 7, back-to-back words, FIFO full and dropped push
        cpol = 0; cpha = 1; div = 8'd7; lsb_first = 0; loop_en = 1;
        repeat (2) @(negedge CLKOSC);
        b_rel = cs_rel;
        for (int i = 0; i < 5; i++) push(w3[i]);
        @(negedge CLKOSC);
        chk("t3_ready_full", {31'd0, tx_ready}, 32'd0);
        tx_data = 8'hEE; tx_valid = 1;
        repeat (3) @(negedge CLKOSC);
        tx_valid = 0;
        chk("t3_ready_still_full", {31'd0, tx_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_rx(400);
            chk("t3_rx_data", {24'd0, rx_data}, {24'd0, w3[i]});
            if (i == 0) chk("t3_ready_at_rx0", {31'd0, tx_ready}, 32'd0);
            if (i == 1) chk("t3_ready_at_rx1", {31'd0, tx_ready}, 32'd1);
            if (i < 4) ack();
        end
        rx_ack = 1; n = 0;
        do begin
            @(negedge CLKOSC);
            rx_ack = 0;
            n++;
        end while (busy && n < 60);
        chk("t3_busy_drop_cycles", n, 32'd16);
        chk("t3_cs_releases", cs_rel - b_rel, 32'd1);
        chk("t3_no_dropped_word", {31'd0, rx_valid}, 32'd0);
        chk("t3_cs_n_idle", {30'd0, spi_cs_n}, 32'd3);

        // 4: overrun
        cpol = 0; cpha = 0; div = 8'd0;
        push(8'h11);
        push(8'h22);
        wait_rx(100);
        chk("t4_rx_first", {24'd0, rx_data}, 32'h11);
        chk("t4_no_ovr_first", {31'd0, overrun}, 32'd0);
        repeat (20) @(negedge CLKOSC);
        chk("t4_overrun", {31'd0, overrun}, 32'd1);
        chk("t4_rx_second", {24'd0, rx_data}, 32'h22);
        chk("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
        clr_ovr = 1;
        @(negedge CLKOSC);
        clr_ovr = 0;
        chk("t4_ovr_cleared", {31'd0, overrun}, 32'd0);
        chk("t4_rx_valid_kept", {31'd0, rx_valid}, 32'd1);
        wait_idle(100);

        // 5: reset mid-SHIFT (rx_valid still set from the previous step)
        div = 8'd3;
        b_rise = sck_rises;
        push(8'h5A);
        push(8'h6B);
        wait_rises(b_rise, 2, 200);
        #2 RST = 1'b1;
        #1;
        chk("t5_cs_n", {30'd0, spi_cs_n}, 32'd3);
        chk("t5_spi_clk", {31'd0, spi_clk}, 32'd0);
        chk("t5_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("t5_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_rx_valid", {31'd0, rx_valid}, 32'd0);
        @(negedge CLKOSC);
        RST = 1'b0;
        repeat (40) @(negedge CLKOSC);
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        chk("t5_rx_valid_after", {31'd0, rx_valid}, 32'd0);

        // 6: CS 1, config changed mid-word
        cs_sel = 1'b1; cpol = 0; cpha = 0; div = 8'd1; lsb_first = 0;
        @(negedge CLKOSC);
        b_rise = sck_rises; b_cs0 = cs0_low; b_cs1 = cs1_low;
        push(8'h3C);
        wait_rises(b_rise, 3, 200);
        cpol = 1; cpha = 1; div = 8'd5; cs_sel = 1'b0; lsb_first = 1;
        wait_rx(300);
        chk("t6_rx_data", {24'd0, rx_data}, 32'h3C);
        ack();
        wait_idle(100);
        chk("t6_cs1_low_cycles", cs1_low - b_cs1, 32'd36);
        chk("t6_cs0_untouched", cs0_low - b_cs0, 32'd0);
        chk("t6_sck_rises", sck_rises - b_rise, 32'd8);
        repeat (2) @(negedge CLKOSC);
        chk("t6_sck_new_cpol", {31'd0, spi_clk}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
